frame_header_parser: RTL and testbench

- Decoder-side counterpart of the frame header/matrix generators.
- Consumes a byte stream that starts at the frame_size word of a ProRes frame and extracts the frame-header fields. Fields are held on registered outputs.
- Luma and chroma quantisation matrices are emitted through a byte write port. Extension bytes are skipped.
- Sits ahead of the picture-header/slice-table parser. Stops exactly at the last header byte so the next parser starts at picture-header byte 0.

---
 rtl/prores_header_pkg.sv | 37 +++
 rtl/byte_field_shifter.sv | 17 +
 rtl/frame_header_parser.sv | 177 +++++++++++++++++
 tb/tb_frame_header_parser.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/prores_header_pkg.sv
// Shared types and constants for the ProRes frame-header parser.
package prores_header_pkg;

    localparam logic [31:0] HDR_MAGIC    = 32'h69637066;
    localparam logic [15:0] HDR_MIN_SIZE = 16'd20;
    localparam logic [15:0] QMAT_BYTES   = 16'd64;

    typedef enum logic [3:0] {
        ST_IDLE, ST_FSIZE, ST_MAGIC, ST_FIELDS, ST_LUMA, ST_CHROMA, ST_SKIP, ST_DONE, ST_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_MAGIC = 2'd1;
    localparam logic [1:0] ERR_HSIZE = 2'd2;
    localparam logic [1:0] ERR_QMAT  = 2'd3;

    // Offset of the last byte of each FIELDS entry that is kept.
    localparam logic [15:0] OFS_HSIZE  = 16'd1;
    localparam logic [15:0] OFS_WIDTH  = 16'd9;
    localparam logic [15:0] OFS_HEIGHT = 16'd11;
    localparam logic [15:0] OFS_FLAGS  = 16'd12;
    localparam logic [15:0] OFS_ARFR   = 16'd13;
    localparam logic [15:0] OFS_CP     = 16'd14;
    localparam logic [15:0] OFS_TC     = 16'd15;
    localparam logic [15:0] OFS_MC     = 16'd16;
    localparam logic [15:0] OFS_ALPHA  = 16'd17;
    localparam logic [15:0] OFS_LOAD   = 16'd19;

    function automatic logic [15:0] need_bytes(input logic luma, input logic chroma);
        logic [15:0] n;
        n = 16'd20;
        if (luma)   n = n + QMAT_BYTES;
        if (chroma) n = n + QMAT_BYTES;
        return n;
    endfunction

endpackage

// File: rtl/byte_field_shifter.sv
// Big-endian byte accumulator: each shift pushes a byte into the low end.
module byte_field_shifter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  din,
    output logic [31:0] value
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)      value <= '0;
        else if (clear)    value <= '0;
        else if (shift_en) value <= {value[23:0], din};
    end

endmodule

// File: rtl/frame_header_parser.sv
// ProRes frame-header parser: extracts header fields, streams out quant
// matrices and stops on the last header byte.
module frame_header_parser
    import prores_header_pkg::*;
#(
    parameter logic [31:0] MAGIC        = HDR_MAGIC,
    parameter logic [15:0] MIN_HDR_SIZE = HDR_MIN_SIZE
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  error_code,
    output logic [31:0] frame_size,
    output logic [15:0] header_size,
    output logic [15:0] horizontal,
    output logic [15:0] vertical,
    output logic [1:0]  chroma_format,
    output logic [1:0]  interlace_mode,
    output logic [3:0]  aspect_ratio_information,
    output logic [3:0]  frame_rate_code,
    output logic [7:0]  color_primaries,
    output logic [7:0]  transfer_characteristic,
    output logic [7:0]  matrix_coefficients,
    output logic [3:0]  alpha_channel_type,
    output logic        luma_loaded,
    output logic        chroma_loaded,
    output logic        qmat_we,
    output logic        qmat_chroma,
    output logic [5:0]  qmat_index,
    output logic [7:0]  qmat_data
);

    localparam logic [15:0] QMAT_LAST = QMAT_BYTES - 16'd1;

    state_t      state, state_nxt;
    logic [15:0] cnt, skip_len, need;
    logic [31:0] acc, word;
    logic [1:0]  err_nxt;
    logic        accept;

    byte_field_shifter u_shift (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (state == ST_IDLE),
        .shift_en (accept),
        .din      (in_data),
        .value    (acc)
    );

    // word already includes the byte being accepted this cycle.
    assign word     = {acc[23:0], in_data};
    assign need     = need_bytes(in_data[1], in_data[0]);
    assign in_ready = (state == ST_FSIZE) || (state == ST_MAGIC) || (state == ST_FIELDS) ||
                      (state == ST_LUMA)  || (state == ST_CHROMA) || (state == ST_SKIP);
    assign busy     = in_ready;
    assign accept   = in_valid && in_ready;
    assign done     = (state == ST_DONE);
    assign error    = (state == ST_ERR);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = ERR_NONE;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_FSIZE;
            ST_FSIZE: if (accept && cnt == 16'd3) state_nxt = ST_MAGIC;
            ST_MAGIC: if (accept && cnt == 16'd3) begin
                if (word != MAGIC) begin
                    state_nxt = ST_ERR;
                    err_nxt   = ERR_MAGIC;
                end else begin
                    state_nxt = ST_FIELDS;
                end
            end
            ST_FIELDS: if (accept) begin
                if (cnt == OFS_HSIZE && word[15:0] < MIN_HDR_SIZE) begin
                    state_nxt = ST_ERR;
                    err_nxt   = ERR_HSIZE;
                end else if (cnt == OFS_LOAD) begin
                    if (header_size < need) begin
                        state_nxt = ST_ERR;
                        err_nxt   = ERR_QMAT;
                    end else if (in_data[1])           state_nxt = ST_LUMA;
                    else if (in_data[0])               state_nxt = ST_CHROMA;
                    else if (header_size != need)      state_nxt = ST_SKIP;
                    else                               state_nxt = ST_DONE;
                end
            end
            ST_LUMA: if (accept && cnt == QMAT_LAST) begin
                if (chroma_loaded)        state_nxt = ST_CHROMA;
                else if (skip_len != '0)  state_nxt = ST_SKIP;
                else                      state_nxt = ST_DONE;
            end
            ST_CHROMA: if (accept && cnt == QMAT_LAST)
                state_nxt = (skip_len != '0) ? ST_SKIP : ST_DONE;
            ST_SKIP: if (accept && cnt == skip_len - 16'd1) state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt                      <= '0;
            skip_len                 <= '0;
            error_code               <= '0;
            frame_size               <= '0;
            header_size              <= '0;
            horizontal               <= '0;
            vertical                 <= '0;
            chroma_format            <= '0;
            interlace_mode           <= '0;
            aspect_ratio_information <= '0;
            frame_rate_code          <= '0;
            color_primaries          <= '0;
            transfer_characteristic  <= '0;
            matrix_coefficients      <= '0;
            alpha_channel_type       <= '0;
            luma_loaded              <= 1'b0;
            chroma_loaded            <= 1'b0;
            qmat_we                  <= 1'b0;
            qmat_chroma              <= 1'b0;
            qmat_index               <= '0;
            qmat_data                <= '0;
        end else begin
            if (state_nxt != state) cnt <= '0;
            else if (accept)        cnt <= cnt + 16'd1;

            if (state == ST_IDLE && start) error_code <= ERR_NONE;
            if (err_nxt != ERR_NONE)       error_code <= err_nxt;

            qmat_we <= accept && (state == ST_LUMA || state == ST_CHROMA);
            if (accept && (state == ST_LUMA || state == ST_CHROMA)) begin
                qmat_chroma <= (state == ST_CHROMA);
                qmat_index  <= cnt[5:0];
                qmat_data   <= in_data;
            end

            if (accept && state == ST_FSIZE && cnt == 16'd3) frame_size <= word;
            if (accept && state == ST_FIELDS) begin
                case (cnt)
                    OFS_HSIZE:  header_size <= word[15:0];
                    OFS_WIDTH:  horizontal  <= word[15:0];
                    OFS_HEIGHT: vertical    <= word[15:0];
                    OFS_FLAGS: begin
                        chroma_format  <= in_data[7:6];
                        interlace_mode <= in_data[3:2];
                    end
                    OFS_ARFR: begin
                        aspect_ratio_information <= in_data[7:4];
                        frame_rate_code          <= in_data[3:0];
                    end
                    OFS_CP:    color_primaries         <= in_data;
                    OFS_TC:    transfer_characteristic <= in_data;
                    OFS_MC:    matrix_coefficients     <= in_data;
                    OFS_ALPHA: alpha_channel_type      <= in_data[3:0];
                    OFS_LOAD: begin
                        luma_loaded   <= in_data[1];
                        chroma_loaded <= in_data[0];
                        skip_len      <= header_size - need;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_header_parser.sv
// Randomized bench for frame_header_parser against a byte-array reference model.
module tb_frame_header_parser;

    logic        clock, reset_n, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, busy, done, error;
    logic [1:0]  error_code;
    logic [31:0] frame_size;
    logic [15:0] header_size, horizontal, vertical;
    logic [1:0]  chroma_format, interlace_mode;
    logic [3:0]  aspect_ratio_information, frame_rate_code, alpha_channel_type;
    logic [7:0]  color_primaries, transfer_characteristic, matrix_coefficients;
    logic        luma_loaded, chroma_loaded, qmat_we, qmat_chroma;
    logic [5:0]  qmat_index;
    logic [7:0]  qmat_data;

    frame_header_parser dut (
        .clock(clock), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .done(done), .error(error), .error_code(error_code),
        .frame_size(frame_size), .header_size(header_size), .horizontal(horizontal),
        .vertical(vertical), .chroma_format(chroma_format), .interlace_mode(interlace_mode),
        .aspect_ratio_information(aspect_ratio_information), .frame_rate_code(frame_rate_code),
        .color_primaries(color_primaries), .transfer_characteristic(transfer_characteristic),
        .matrix_coefficients(matrix_coefficients), .alpha_channel_type(alpha_channel_type),
        .luma_loaded(luma_loaded), .chroma_loaded(chroma_loaded), .qmat_we(qmat_we),
        .qmat_chroma(qmat_chroma), .qmat_index(qmat_index), .qmat_data(qmat_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0]  stim[$];
    logic [14:0] exp_q[$], got_q[$];
    int          exp_consumed, exp_code;
    logic [31:0] e_fs;
    logic [15:0] e_hs, e_w, e_h;
    logic [7:0]  e_flags, e_arfr, e_cp, e_tc, e_mc, e_alpha, e_load;

    task automatic build(input logic [31:0] fs, input logic [31:0] mg, input logic [15:0] hs,
                         input logic [15:0] w, input logic [15:0] h, input logic [7:0] flags,
                         input logic [7:0] arfr, input logic [7:0] cp, input logic [7:0] tc,
                         input logic [7:0] mc, input logic [7:0] alpha, input logic [7:0] load,
                         input logic [7:0] seed);
        int need;
        stim.delete();
        for (int i = 3; i >= 0; i--) stim.push_back(fs[8*i +: 8]);
        for (int i = 3; i >= 0; i--) stim.push_back(mg[8*i +: 8]);
        stim.push_back(hs[15:8]); stim.push_back(hs[7:0]);
        for (int i = 0; i < 6; i++) stim.push_back(8'($urandom));
        stim.push_back(w[15:8]); stim.push_back(w[7:0]);
        stim.push_back(h[15:8]); stim.push_back(h[7:0]);
        stim.push_back(flags); stim.push_back(arfr); stim.push_back(cp);
        stim.push_back(tc); stim.push_back(mc); stim.push_back(alpha);
        stim.push_back(8'($urandom)); stim.push_back(load);
        if (load[1]) for (int i = 0; i < 64; i++) stim.push_back(8'(seed + i));
        if (load[0]) for (int i = 0; i < 64; i++) stim.push_back(8'(seed + 64 + i));
        need = 20 + 64 * int'(load[1]) + 64 * int'(load[0]);
        for (int i = need; i < int'(hs); i++) stim.push_back(8'($urandom));
        for (int i = 0; i < 4; i++) stim.push_back(8'($urandom));
    endtask

    // Reference: decode the byte array directly from the header layout.
    task automatic model();
        int hs, need, l, c;
        exp_q.delete();
        e_fs = {stim[0], stim[1], stim[2], stim[3]};
        e_hs = {stim[8], stim[9]};
        e_w  = {stim[16], stim[17]};
        e_h  = {stim[18], stim[19]};
        e_flags = stim[20]; e_arfr = stim[21]; e_cp = stim[22]; e_tc = stim[23];
        e_mc = stim[24]; e_alpha = stim[25]; e_load = stim[27];
        hs = int'(e_hs);
        l = int'(e_load[1]); c = int'(e_load[0]);
        need = 20 + 64 * l + 64 * c;
        if ({stim[4], stim[5], stim[6], stim[7]} != 32'h69637066) begin
            exp_code = 1; exp_consumed = 8;
        end else if (hs < 20) begin
            exp_code = 2; exp_consumed = 10;
        end else if (hs < need) begin
            exp_code = 3; exp_consumed = 28;
        end else begin
            exp_code = 0; exp_consumed = 8 + hs;
            for (int i = 0; i < 64 * l; i++) exp_q.push_back({1'b0, 6'(i), stim[28 + i]});
            for (int i = 0; i < 64 * c; i++) exp_q.push_back({1'b1, 6'(i), stim[28 + 64 * l + i]});
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rdy"}, in_ready, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, error, 0);
        chk({tag, "_ecode"}, error_code, 0);
        chk({tag, "_fs"}, frame_size, 0);
        chk({tag, "_hs"}, header_size, 0);
        chk({tag, "_w"}, horizontal, 0);
        chk({tag, "_ll"}, luma_loaded, 0);
        chk({tag, "_cl"}, chroma_loaded, 0);
        chk({tag, "_qwe"}, qmat_we, 0);
        chk({tag, "_qidx"}, qmat_index, 0);
        chk({tag, "_qdat"}, qmat_data, 0);
    endtask

    task automatic run_frame(input int gap, input int abort_at);
        int  idx;
        bit  fin;
        logic got_done;
        logic [1:0] got_code;
        got_q.delete();
        idx = 0; fin = 0; got_done = 0; got_code = 0;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        chk("busy_start", busy, 1);
        chk("ecode_clr", error_code, 0);
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            if (abort_at >= 0 && idx == abort_at) begin
                reset_n = 1'b0;
                #1 check_zero("abort");
                in_valid = 1'b0;
                @(negedge clock) reset_n = 1'b1;
                return;
            end
            in_valid = (idx < stim.size()) && ($urandom_range(99) >= gap);
            in_data  = (idx < stim.size()) ? stim[idx] : 8'($urandom);
            @(negedge clock);
            if (qmat_we) got_q.push_back({qmat_chroma, qmat_index, qmat_data});
            if (done || error) begin
                fin = 1;
                got_done = done;
                got_code = error ? error_code : 2'd0;
                chk("busy_end", busy, 0);
            end else if (in_valid && in_ready) begin
                idx++;
            end
            @(posedge clock); #1;
        end
        if (!fin) chk("timeout", 0, 1);
        chk("consumed", idx, exp_consumed);
        chk("done", got_done, exp_code == 0);
        chk("ecode", got_code, exp_code);
        in_valid = 1'b1;
        in_data  = (idx < stim.size()) ? stim[idx] : 8'h00;
        @(negedge clock);
        chk("done_1cyc", done, 0);
        chk("err_1cyc", error, 0);
        chk("rdy_after", in_ready, 0);
        if (exp_code != 0) chk("ecode_hold", error_code, exp_code);
        @(posedge clock); #1 in_valid = 1'b0;
        chk("qmat_cnt", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("qmat[%0d]", i), got_q[i], exp_q[i]);
        if (exp_code == 0) begin
            chk("frame_size", frame_size, e_fs);
            chk("header_size", header_size, e_hs);
            chk("horizontal", horizontal, e_w);
            chk("vertical", vertical, e_h);
            chk("chroma_fmt", chroma_format, e_flags[7:6]);
            chk("interlace", interlace_mode, e_flags[3:2]);
            chk("aspect", aspect_ratio_information, e_arfr[7:4]);
            chk("frame_rate", frame_rate_code, e_arfr[3:0]);
            chk("color_prim", color_primaries, e_cp);
            chk("transfer", transfer_characteristic, e_tc);
            chk("matrix", matrix_coefficients, e_mc);
            chk("alpha", alpha_channel_type, e_alpha[3:0]);
            chk("luma_ld", luma_loaded, e_load[1]);
            chk("chroma_ld", chroma_loaded, e_load[0]);
        end
    endtask

    task automatic nominal();
        build(32'h00012345, 32'h69637066, 16'd148, 16'd1920, 16'd1080, 8'h80, 8'h13,
              8'd1, 8'd1, 8'd1, 8'd0, 8'h03, 8'd0);
        model();
    endtask

    initial begin
        int need, l, c, hs, mode;
        logic [31:0] mg;
        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #12 check_zero("reset");
        @(negedge clock) reset_n = 1'b1;

        nominal();
        run_frame(0, -1);
        build(32'h00012345, 32'h69637058, 16'd148, 16'd1920, 16'd1080, 8'h80, 8'h13,
              8'd1, 8'd1, 8'd1, 8'd0, 8'h03, 8'd0);
        model(); run_frame(0, -1);
        build(32'h100, 32'h69637066, 16'd16, 16'd64, 16'd32, 8'h40, 8'h22,
              8'd2, 8'd3, 8'd4, 8'd1, 8'h03, 8'd5);
        model(); run_frame(0, -1);
        build(32'h200, 32'h69637066, 16'd84, 16'd64, 16'd32, 8'h40, 8'h22,
              8'd2, 8'd3, 8'd4, 8'd1, 8'h03, 8'd5);
        model(); run_frame(0, -1);
        build(32'h300, 32'h69637066, 16'd30, 16'd720, 16'd486, 8'hCC, 8'h45,
              8'd6, 8'd7, 8'd8, 8'd2, 8'h00, 8'd9);
        model(); run_frame(0, -1);
        build(32'h400, 32'h69637066, 16'd20, 16'd1, 16'd1, 8'hFF, 8'hFF,
              8'd255, 8'd255, 8'd255, 8'hFF, 8'hFC, 8'd9);
        model(); run_frame(0, -1);
        nominal();
        run_frame(50, -1);
        nominal();
        run_frame(0, 58);
        nominal();
        run_frame(0, -1);

        for (int t = 0; t < 24; t++) begin
            l = int'($urandom_range(1)); c = int'($urandom_range(1));
            need = 20 + 64 * l + 64 * c;
            hs = need + int'($urandom_range(12));
            mg = 32'h69637066;
            mode = int'($urandom_range(9));
            if (mode == 0) mg = mg ^ (32'd1 << $urandom_range(31));
            if (mode == 1) hs = int'($urandom_range(19));
            if (mode == 2 && need > 20) hs = int'($urandom_range(need - 1, 20));
            build($urandom, mg, 16'(hs), 16'($urandom), 16'($urandom), 8'($urandom),
                  8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  {6'($urandom), 1'(l), 1'(c)}, 8'($urandom));
            model();
            run_frame(int'($urandom_range(1)) * 50, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
